// File: rtl/mic1_uart_loader.sv
// Serial boot loader for the Mic-1: 8N1 receiver plus frame parser that fills
// main memory and the microprogram store. Checksum byte via MIC1_LOADER_CHECKSUM_EN.
module mic1_uart_loader #(
    parameter int CLK_DIV = 868,
    parameter int MP_AW   = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_rx,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mp_we,
    output logic [MP_AW-1:0] mp_addr,
    output logic [35:0]      mp_wdata,
    output logic             cpu_resetn,
    output logic             busy,
    output logic             err
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_FULL = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_st_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_WRITE
`ifdef MIC1_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } st_t;

`ifdef MIC1_LOADER_CHECKSUM_EN
    localparam st_t S_END = S_CSUM;
`else
    localparam st_t S_END = S_IDLE;
`endif

    // ---------------- UART receiver ----------------
    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          r_rx_prev;
    rx_st_t        r_rx_st;
    rx_st_t        w_rx_nxt;
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_rx_valid;
    logic          r_ferr;
    logic          w_div_hit;
    logic          w_div_clr;
    logic          w_shift_en;
    logic          w_stop_ok;
    logic          w_stop_bad;

    always_comb begin
        w_rx_nxt   = r_rx_st;
        w_div_clr  = 1'b0;
        w_shift_en = 1'b0;
        w_stop_ok  = 1'b0;
        w_stop_bad = 1'b0;
        w_div_hit  = (r_rx_st == RX_START) ? (r_div == DIV_HALF)
                                           : (r_div == DIV_FULL);
        case (r_rx_st)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_nxt  = RX_START;
                    w_div_clr = 1'b1;
                end
            end
            RX_START: begin
                if (w_div_hit) begin
                    w_div_clr = 1'b1;
                    w_rx_nxt  = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_div_hit) begin
                    w_div_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_rx_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (w_div_hit) begin
                    w_div_clr  = 1'b1;
                    w_rx_nxt   = RX_IDLE;
                    w_stop_ok  = r_rx_sync;
                    w_stop_bad = !r_rx_sync;
                end
            end
            default: w_rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_st    <= RX_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_rx_valid <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_rx_meta  <= ser_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_st    <= w_rx_nxt;
            r_div      <= w_div_clr ? '0 : r_div + 1'b1;
            r_rx_valid <= w_stop_ok;
            r_ferr     <= w_stop_bad;
            if (r_rx_st == RX_START) begin
                r_bit <= '0;
            end else if (w_shift_en) begin
                r_bit <= r_bit + 1'b1;
            end
            if (w_shift_en) begin
                r_shift <= {r_rx_sync, r_shift[7:1]};
            end
        end
    end

    // ---------------- Frame parser ----------------
    st_t             r_st;
    st_t             w_st_nxt;
    logic            r_sel_mp;
    logic [7:0]      r_hi;
    logic [15:0]     r_cnt;
    logic [2:0]      r_byte_idx;
    logic [27:0]     r_word;
    logic [31:0]     r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic [MP_AW-1:0] r_mp_addr;
    logic [35:0]     r_mp_wdata;
    logic            r_cpu_run;
    logic            r_err;
    logic [15:0]     w_hw;
    logic            w_last_byte;
    logic            w_mem_we;
    logic            w_mp_we;
    logic            w_busy;
`ifdef MIC1_LOADER_CHECKSUM_EN
    logic [7:0]      r_sum;
    logic [7:0]      w_sum_chk;
    assign w_sum_chk = r_sum + r_shift;
`endif

    assign w_hw        = {r_hi, r_shift};
    assign w_last_byte = (r_byte_idx == (r_sel_mp ? 3'd4 : 3'd3));

    always_comb begin
        w_st_nxt = r_st;
        w_mem_we = 1'b0;
        w_mp_we  = 1'b0;
        w_busy   = (r_st != S_IDLE);
        case (r_st)
            S_IDLE: begin
                if (r_rx_valid &&
                    (r_shift == 8'hA5 || r_shift == 8'h5A)) begin
                    w_st_nxt = S_ADDR_HI;
                end
            end
            S_ADDR_HI: if (r_rx_valid) w_st_nxt = S_ADDR_LO;
            S_ADDR_LO: if (r_rx_valid) w_st_nxt = S_CNT_HI;
            S_CNT_HI:  if (r_rx_valid) w_st_nxt = S_CNT_LO;
            S_CNT_LO: begin
                if (r_rx_valid) begin
                    w_st_nxt = (w_hw == 16'd0) ? S_END : S_DATA;
                end
            end
            S_DATA: begin
                if (r_rx_valid && w_last_byte) begin
                    w_st_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_mem_we = !r_sel_mp;
                w_mp_we  = r_sel_mp;
                w_st_nxt = (r_cnt == 16'd1) ? S_END : S_DATA;
            end
`ifdef MIC1_LOADER_CHECKSUM_EN
            S_CSUM: if (r_rx_valid) w_st_nxt = S_IDLE;
`endif
            default: w_st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st <= S_IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_mp    <= 1'b0;
            r_hi        <= '0;
            r_cnt       <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mp_addr   <= '0;
            r_mp_wdata  <= '0;
            r_cpu_run   <= 1'b0;
            r_err       <= 1'b0;
`ifdef MIC1_LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            if (r_ferr) begin
                r_err <= 1'b1;
            end
            if (r_rx_valid) begin
`ifdef MIC1_LOADER_CHECKSUM_EN
                r_sum <= w_sum_chk;
`endif
                case (r_st)
                    S_IDLE: begin
                        if (r_shift == 8'hA5 || r_shift == 8'h5A) begin
                            r_sel_mp  <= (r_shift == 8'h5A);
                            r_cpu_run <= 1'b0;
`ifdef MIC1_LOADER_CHECKSUM_EN
                            r_sum     <= r_shift;
`endif
                        end else if (r_shift == 8'h47) begin
                            r_cpu_run <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    S_ADDR_HI, S_CNT_HI: r_hi <= r_shift;
                    S_ADDR_LO: begin
                        if (r_sel_mp) begin
                            r_mp_addr <= MP_AW'(w_hw);
                        end else begin
                            r_mem_addr <= {16'h0000, w_hw};
                        end
                    end
                    S_CNT_LO: begin
                        r_cnt      <= w_hw;
                        r_byte_idx <= '0;
                    end
                    S_DATA: begin
                        r_word <= {r_word[19:0], r_shift};
                        if (w_last_byte) begin
                            r_byte_idx <= '0;
                            if (r_sel_mp) begin
                                r_mp_wdata <= {r_word[27:0], r_shift};
                            end else begin
                                r_mem_wdata <= {r_word[23:0], r_shift};
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end
`ifdef MIC1_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (w_sum_chk != 8'h00) begin
                            r_err <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
            // Address advances on the edge that ends the strobe
            if (r_st == S_WRITE) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_sel_mp) begin
                    r_mp_addr <= r_mp_addr + 1'b1;
                end else begin
                    r_mem_addr <= r_mem_addr + 1'b1;
                end
            end
        end
    end

    assign mem_we     = w_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mp_we      = w_mp_we;
    assign mp_addr    = r_mp_addr;
    assign mp_wdata   = r_mp_wdata;
    assign cpu_resetn = r_cpu_run;
    assign busy       = w_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_mic1_uart_loader.sv
// Bench for mic1_uart_loader: byte-level frame model, per-cycle write compare,
// directed cases plus random frames.
module tb_mic1_uart_loader;

    localparam int CLK_DIV = 16;
    localparam int MP_AW   = 9;
    localparam logic [63:0] MP_SIZE = 64'(1) << MP_AW;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ser_rx = 1'b1;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mp_we;
    logic [MP_AW-1:0] mp_addr;
    logic [35:0]      mp_wdata;
    logic             cpu_resetn;
    logic             busy;
    logic             err;

    always #5 clk = ~clk;

    mic1_uart_loader #(.CLK_DIV(CLK_DIV), .MP_AW(MP_AW)) dut (
        .clk(clk), .reset(reset), .ser_rx(ser_rx),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mp_we(mp_we), .mp_addr(mp_addr), .mp_wdata(mp_wdata),
        .cpu_resetn(cpu_resetn), .busy(busy), .err(err)
    );

    typedef struct {
        bit          mp;
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    int  n_checks = 0;
    int  n_fail = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];
    wr_t cmp_e;
    wr_t cmp_o;
    bit  settled = 1'b0;
    logic [7:0] fq[$];

    // Frame model: state 0 idle, 1..4 header, 5 data, 6 checksum
    int          m_st = 0;
    bit          m_mp = 1'b0;
    logic [63:0] m_addr = '0;
    int          m_cnt = 0;
    int          m_nb = 0;
    logic [63:0] m_word = '0;
    logic [7:0]  m_hi = '0;
    logic [7:0]  m_sum = '0;
    bit          m_err = 1'b0;
    bit          m_cpu = 1'b0;
`ifdef MIC1_LOADER_CHECKSUM_EN
    localparam int M_END = 6;
`else
    localparam int M_END = 0;
`endif

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_st = 0;
        m_err = 1'b0;
        m_cpu = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        wr_t w;
        if (m_st >= 1 && m_st <= 5) m_sum = m_sum + b;
        case (m_st)
            0: begin
                if (b == 8'hA5 || b == 8'h5A) begin
                    m_mp = (b == 8'h5A);
                    m_cpu = 1'b0;
                    m_sum = b;
                    m_st = 1;
                end else if (b == 8'h47) begin
                    m_cpu = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            1: begin m_hi = b; m_st = 2; end
            2: begin
                m_addr = 64'({m_hi, b});
                if (m_mp) m_addr = m_addr % MP_SIZE;
                m_st = 3;
            end
            3: begin m_hi = b; m_st = 4; end
            4: begin
                m_cnt = int'({m_hi, b});
                m_nb = 0;
                m_word = '0;
                m_st = (m_cnt == 0) ? M_END : 5;
            end
            5: begin
                m_word = (m_word << 8) | 64'(b);
                m_nb++;
                if (m_nb == (m_mp ? 5 : 4)) begin
                    w.mp = m_mp;
                    w.addr = m_addr;
                    w.data = m_mp ? (m_word & 64'hF_FFFF_FFFF) : m_word;
                    exp_q.push_back(w);
                    m_addr = m_mp ? (m_addr + 1) % MP_SIZE
                                  : (m_addr + 1) & 64'hFFFF_FFFF;
                    m_cnt--;
                    m_nb = 0;
                    m_word = '0;
                    if (m_cnt == 0) m_st = M_END;
                end
            end
            6: begin
                if (8'(m_sum + b) != 8'h00) m_err = 1'b1;
                m_st = 0;
            end
            default: m_st = 0;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (mem_we || mp_we) begin
                cmp_o.mp = mp_we;
                cmp_o.addr = mp_we ? 64'(mp_addr) : 64'(mem_addr);
                cmp_o.data = mp_we ? 64'(mp_wdata) : 64'(mem_wdata);
                obs_q.push_back(cmp_o);
                chk("we_both", 64'(mem_we & mp_we), 64'd0);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write addr=%0h data=%0h",
                             cmp_o.addr, cmp_o.data);
                end else begin
                    cmp_e = exp_q.pop_front();
                    chk("wr_target", 64'(cmp_o.mp), 64'(cmp_e.mp));
                    chk("wr_addr", cmp_o.addr, cmp_e.addr);
                    chk("wr_data", cmp_o.data, cmp_e.data);
                end
            end
            if (settled) begin
                chk("busy", 64'(busy), 64'(m_st != 0));
                chk("err", 64'(err), 64'(m_err));
                chk("cpu_resetn", 64'(cpu_resetn), 64'(m_cpu));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        settled = 1'b0;
        if (stop_ok) model_byte(b);
        else m_err = 1'b1;
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        ser_rx = stop_ok;
        repeat (CLK_DIV) @(negedge clk);
        ser_rx = 1'b1;
        repeat (4) @(negedge clk);
        settled = 1'b1;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] bs[$]);
        logic [7:0] s;
        s = '0;
        foreach (bs[i]) begin
            s = s + bs[i];
            send_byte(bs[i]);
        end
`ifdef MIC1_LOADER_CHECKSUM_EN
        send_byte(8'(8'h00 - s));
`endif
    endtask

    task automatic glitch();
        settled = 1'b0;
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (4) @(negedge clk);
        ser_rx = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        settled = 1'b1;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_mp_we"}, 64'(mp_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mp_addr"}, 64'(mp_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_mp_wdata"}, 64'(mp_wdata), 64'd0);
        chk({tag, "_cpu_resetn"}, 64'(cpu_resetn), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        int nwords;
        bit mp;
        logic [15:0] a;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Main memory single word
        obs_q.delete();
        fq = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01,
               8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(fq);
        chk("t1_nwr", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() >= 1) begin
            chk("t1_addr", obs_q[0].addr, 64'h10);
            chk("t1_data", obs_q[0].data, 64'hDEAD_BEEF);
        end
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_cpu", 64'(cpu_resetn), 64'd0);

        // Microprogram with address wrap
        obs_q.delete();
        fq = '{8'h5A, 8'h01, 8'hFF, 8'h00, 8'h02,
               8'hF1, 8'h23, 8'h45, 8'h67, 8'h89,
               8'h0A, 8'hBC, 8'hDE, 8'hF0, 8'h12};
        send_frame(fq);
        chk("t2_nwr", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() >= 2) begin
            chk("t2_mp0", 64'(obs_q[0].mp), 64'd1);
            chk("t2_addr0", obs_q[0].addr, 64'h1FF);
            chk("t2_data0", obs_q[0].data, 64'h1_2345_6789);
            chk("t2_addr1", obs_q[1].addr, 64'h000);
            chk("t2_data1", obs_q[1].data, 64'hA_BCDE_F012);
        end

        // Go, then re-hold by a new frame header
        send_byte(8'h47);
        chk("t3_go", 64'(cpu_resetn), 64'd1);
        send_byte(8'hA5);
        chk("t3_hold", 64'(cpu_resetn), 64'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
`ifdef MIC1_LOADER_CHECKSUM_EN
        send_byte(8'h5B);
`endif

        // Framing error and unknown idle byte
        obs_q.delete();
        send_byte(8'h81, 1'b0);
        send_byte(8'h33);
        chk("t4_err", 64'(err), 64'd1);
        chk("t4_nwr", 64'(obs_q.size()), 64'd0);

        // Reset mid-frame, glitch, then a clean frame
        fq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'hAA};
        foreach (fq[i]) send_byte(fq[i]);
        chk("t5_busy_pre", 64'(busy), 64'd1);
        settled = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        glitch();
        chk("t5_glitch_err", 64'(err), 64'd0);
        chk("t5_glitch_busy", 64'(busy), 64'd0);
        obs_q.delete();
        fq = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'h01,
               8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(fq);
        chk("t5_nwr", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() >= 1) begin
            chk("t5_addr", obs_q[0].addr, 64'h1234);
            chk("t5_data", obs_q[0].data, 64'h0102_0304);
        end

`ifdef MIC1_LOADER_CHECKSUM_EN
        fq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5B};
        foreach (fq[i]) send_byte(fq[i]);
        chk("cs_good", 64'(err), 64'd0);
        fq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        foreach (fq[i]) send_byte(fq[i]);
        chk("cs_bad", 64'(err), 64'd1);
`endif

        // Random frames with occasional junk and go bytes
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 63)));
            if ($urandom_range(0, 3) == 0) send_byte(8'h47);
            mp = 1'($urandom_range(0, 1));
            nwords = $urandom_range(0, 2);
            a = ($urandom_range(0, 2) == 0) ? 16'h01FF
                                            : 16'($urandom_range(0, 65535));
            fq.delete();
            fq.push_back(mp ? 8'h5A : 8'hA5);
            fq.push_back(a[15:8]);
            fq.push_back(a[7:0]);
            fq.push_back(8'h00);
            fq.push_back(8'(nwords));
            for (int k = 0; k < nwords * (mp ? 5 : 4); k++) begin
                fq.push_back(8'($urandom_range(0, 255)));
            end
            send_frame(fq);
        end

        settled = 1'b0;
        repeat (50) @(negedge clk);
        chk("exp_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
